// File: rtl/doomsday_alarm.sv
// Countdown supervisor: watches the timer's BCD digits and drives the buzzer, LED bar and display blank.
// Digits are registered as zero/warn flags first, so a digit change reaches state two edges later.
module doomsday_alarm #(
  parameter int TONE_DIV    = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter int WARN_SECS   = 10,
  parameter int ALARM_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bin0,
  input  logic [3:0] bin1,
  input  logic [3:0] bin2,
  input  logic [3:0] bin3,
  input  logic       tick,
  input  logic       ack,
  output logic       buzz,
  output logic       blank,
  output logic [7:0] led,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WARN  = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int TICK_W = $clog2(ALARM_TICKS + 1);
  localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(TONE_DIV - 1);
  localparam logic [25:0]       BLINK_LAST = 26'(BLINK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_MAX   = TICK_W'(ALARM_TICKS);
  localparam logic [6:0]        WARN_LIM   = 7'(WARN_SECS);

  state_e              state_q, state_d;
  logic                zero_q, zero_d;
  logic                warn_q, warn_d;
  logic [25:0]         blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic                buzz_q, buzz_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]          led_q, led_d;
  logic                blank_q, blank_d;
  logic                digits_ok;
  logic [6:0]          secs;

  // Stage 1: any non-BCD digit makes the count nonzero and never a warning.
  always_comb begin
    digits_ok = (bin0 <= 4'd9) && (bin1 <= 4'd9) && (bin2 <= 4'd9) && (bin3 <= 4'd9);
    secs      = 7'(bin1) * 7'd10 + 7'(bin0);
    zero_d    = (bin0 == 4'd0) && (bin1 == 4'd0) && (bin2 == 4'd0) && (bin3 == 4'd0);
    warn_d    = digits_ok && (bin3 == 4'd0) && (bin2 == 4'd0) &&
                (secs >= 7'd1) && (secs <= WARN_LIM);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!zero_q) state_d = warn_q ? ST_WARN : ST_ARMED;
      end
      ST_ARMED: begin
        if (zero_q)      state_d = ST_ALARM;
        else if (warn_q) state_d = ST_WARN;
      end
      ST_WARN: begin
        if (zero_q)       state_d = ST_ALARM;
        else if (!warn_q) state_d = ST_ARMED;
      end
      ST_ALARM: begin
        if (ack)                       state_d = ST_IDLE;
        else if (tick_cnt_q == TICK_MAX) state_d = ST_IDLE;
        else if (!zero_q)              state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters and outputs are computed against the next state so they land on the same edge.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 26'd1;
    phase_d     = phase_q;
    if (state_d != state_q) begin
      blink_cnt_d = 26'd0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = 26'd0;
      phase_d     = ~phase_q;
    end

    tone_cnt_d = '0;
    buzz_d     = 1'b0;
    if (state_d == ST_ALARM && state_q == ST_ALARM) begin
      buzz_d = buzz_q;
      if (tone_cnt_q == TONE_LAST) begin
        buzz_d = ~buzz_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
    end

    tick_cnt_d = '0;
    if (state_d == ST_ALARM && state_q == ST_ALARM) begin
      tick_cnt_d = tick_cnt_q;
      if (tick && tick_cnt_q != TICK_MAX) tick_cnt_d = tick_cnt_q + 1'b1;
    end

    led_d   = 8'h00;
    blank_d = 1'b0;
    case (state_d)
      ST_ARMED: led_d = 8'h01;
      ST_WARN:  led_d = phase_d ? 8'hFF : 8'h00;
      ST_ALARM: begin
        led_d   = phase_d ? 8'h55 : 8'hAA;
        blank_d = phase_d;
      end
      default:  led_d = 8'h00;
    endcase
  end

  // zero_q resets high so a zero count after reset cannot look like a reload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      zero_q      <= 1'b1;
      warn_q      <= 1'b0;
      blink_cnt_q <= 26'd0;
      phase_q     <= 1'b0;
      tone_cnt_q  <= '0;
      buzz_q      <= 1'b0;
      tick_cnt_q  <= '0;
      led_q       <= 8'h00;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_q      <= zero_d;
      warn_q      <= warn_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      tone_cnt_q  <= tone_cnt_d;
      buzz_q      <= buzz_d;
      tick_cnt_q  <= tick_cnt_d;
      led_q       <= led_d;
      blank_q     <= blank_d;
    end
  end

  assign buzz  = buzz_q;
  assign blank = blank_q;
  assign led   = led_q;
  assign state = state_q;

endmodule

// File: tb/tb_doomsday_alarm.sv
// Directed bench for doomsday_alarm with short dividers so every state and output phase is reached quickly.
module tb_doomsday_alarm;

  logic       clk;
  logic       reset;
  logic [3:0] bin0, bin1, bin2, bin3;
  logic       tick;
  logic       ack;
  logic       buzz;
  logic       blank;
  logic [7:0] led;
  logic [1:0] state;

  int total;
  int bad;

  doomsday_alarm #(
    .TONE_DIV   (4),
    .BLINK_DIV  (8),
    .WARN_SECS  (10),
    .ALARM_TICKS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bin0 (bin0),
    .bin1 (bin1),
    .bin2 (bin2),
    .bin3 (bin3),
    .tick (tick),
    .ack  (ack),
    .buzz (buzz),
    .blank(blank),
    .led  (led),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [15:0] d);
    {bin3, bin2, bin1, bin0} = d;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic bz,
                         input logic bl, input logic [7:0] ld);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".buzz"},  32'(buzz),  32'(bz));
    chk({tag, ".blank"}, 32'(blank), 32'(bl));
    chk({tag, ".led"},   32'(led),   32'(ld));
  endtask

  task automatic enter_alarm_from_idle();
    set_digits(16'h0130);
    step(2);
    chk("arm_before_alarm", 32'(state), 32'd1);
    set_digits(16'h0000);
    step(2);
    chk("alarm_entry", 32'(state), 32'd3);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    tick  = 1'b0;
    ack   = 1'b0;
    set_digits(16'h0000);
    step(3);
    chk_out("reset", 2'd0, 1'b0, 1'b0, 8'h00);

    // Power-up with a zero count must never alarm.
    reset = 1'b1;
    step(50);
    chk_out("idle_zero_50", 2'd0, 1'b0, 1'b0, 8'h00);

    // 01:30 -> ARMED two edges later.
    set_digits(16'h0130);
    step(1);
    chk("arm_latency_1", 32'(state), 32'd0);
    step(1);
    chk_out("armed", 2'd1, 1'b0, 1'b0, 8'h01);

    // 00:10 -> WARN, LED flashes 00/FF every 8 cycles.
    set_digits(16'h0010);
    step(2);
    chk_out("warn_entry", 2'd2, 1'b0, 1'b0, 8'h00);
    step(7);
    chk("warn_led_e7", 32'(led), 32'h00);
    step(1);
    chk("warn_led_e8", 32'(led), 32'hFF);
    step(8);
    chk("warn_led_e16", 32'(led), 32'h00);

    // 00:11 is above the threshold -> back to ARMED.
    set_digits(16'h0011);
    step(1);
    chk("unwarn_latency_1", 32'(state), 32'd2);
    step(1);
    chk_out("unwarn", 2'd1, 1'b0, 1'b0, 8'h01);

    // WARN -> 00:00 -> ALARM, tone every 4 cycles, blink every 8.
    set_digits(16'h0010);
    step(2);
    chk("warn_again", 32'(state), 32'd2);
    set_digits(16'h0000);
    step(1);
    chk("alarm_latency_1", 32'(state), 32'd2);
    step(1);
    chk_out("alarm_entry_e0", 2'd3, 1'b0, 1'b0, 8'hAA);
    step(3);
    chk("alarm_buzz_e3", 32'(buzz), 32'd0);
    step(1);
    chk("alarm_buzz_e4", 32'(buzz), 32'd1);
    step(4);
    chk_out("alarm_e8", 2'd3, 1'b0, 1'b1, 8'h55);

    // ack exits ALARM on the next edge.
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk_out("ack_exit", 2'd0, 1'b0, 1'b0, 8'h00);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    chk_out("ack_in_idle", 2'd0, 1'b0, 1'b0, 8'h00);

    // Self-silence after ALARM_TICKS ticks.
    enter_alarm_from_idle();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
      if (i == 1) chk("tick_2_still_alarm", 32'(state), 32'd3);
    end
    step(1);
    chk_out("tick_exit", 2'd0, 1'b0, 1'b0, 8'h00);
    step(10);
    chk("no_retrigger", 32'(state), 32'd0);

    // ack beats a same-cycle reload; the reload then arms from IDLE.
    enter_alarm_from_idle();
    ack = 1'b1;
    set_digits(16'h0500);
    step(1);
    ack = 1'b0;
    chk("ack_reload_idle", 32'(state), 32'd0);
    step(1);
    chk_out("ack_reload_armed", 2'd1, 1'b0, 1'b0, 8'h01);

    // Reset while buzzing clears everything on that edge.
    set_digits(16'h0000);
    step(2);
    chk("alarm_for_reset", 32'(state), 32'd3);
    step(4);
    chk("buzz_before_reset", 32'(buzz), 32'd1);
    reset = 1'b0;
    step(1);
    chk_out("reset_mid_alarm", 2'd0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    step(5);
    chk_out("after_reset_idle", 2'd0, 1'b0, 1'b0, 8'h00);

    // Invalid BCD counts as nonzero, never as warning.
    set_digits(16'h0A00);
    step(2);
    chk("bad_bcd_min_armed", 32'(state), 32'd1);
    step(5);
    chk("bad_bcd_min_stays", 32'(state), 32'd1);
    set_digits(16'h000A);
    step(2);
    chk("bad_bcd_sec_not_warn", 32'(state), 32'd1);

    // Lower warning boundary 00:01, and 01:00 is not a warning.
    set_digits(16'h0001);
    step(2);
    chk("warn_one_sec", 32'(state), 32'd2);
    set_digits(16'h0100);
    step(2);
    chk("one_min_armed", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
